mem_access_unit: RTL



---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-stage access unit.
package mem_access_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  // A request is legal when it names exactly one operation, is word aligned
  // and lies inside the addressable data memory.
  function automatic logic req_is_legal(input logic        ld,
                                        input logic        st,
                                        input logic [31:0] addr,
                                        input int unsigned addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + 32'd2);
    return (ld ^ st) && (addr[1:0] == 2'b00) && (upper == 32'd0);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage front end: validates load/store requests, drives the BRAM port
// and returns one registered response per request after the read latency.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  accept;
  logic                  legal;

  assign req_ready = (state_q == IDLE);
  // Reset blocks acceptance so the BRAM is never touched while rst is high.
  assign accept    = req_valid && req_ready && !rst;
  assign legal     = req_is_legal(req_load, req_store, req_addr, ADDR_WIDTH);

  assign mem_en    = accept && legal;
  assign mem_we    = accept && legal && req_store;
  assign mem_addr  = req_addr[ADDR_WIDTH+1:2];
  assign mem_wdata = req_wdata;

  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal && req_load) begin
            state_d = LOAD_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end else begin
            // Stores and rejected requests complete in the following cycle.
            resp_valid_d = 1'b1;
            resp_error_d = !legal;
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule
